add_sub_serial: RTL and testbench
=================================

Name: add_sub_serial

Overview:
Parametrised digit-serial adder/subtractor. It takes two WIDTH-bit operands and processes DIGIT bits per clock, LSB first. It produces a WIDTH-bit result, carry-out and signed overflow, and holds them until the consumer acknowledges. It is the generalised successor to the fixed 8-bit, 1-bit-per-cycle serial adder in the arithmetic datapath library. It adds operand width, digit size, a subtract mode, status flags and a done/ack handshake.

Parameters:
- WIDTH, 8: operand and result width in bits. Must be ≥ 2.
- DIGIT, 1: bits processed per RUN cycle. Must divide WIDTH exactly. Define NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a−b. Sampled with start.
- a  input  WIDTH  operand A. Sampled with start.
- b  input  WIDTH  operand B. Sampled with start.
- ack  input  1  consumer has taken the result. Sampled only in DONE.
- busy  output  1  high in RUN.
- done  output  1  high in DONE; result, cout and ovf are valid while it is high.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, result=0, cout=0, ovf=0, internal carry=0, digit counter=0. A reset during RUN abandons the operation; no partial result is kept.
- States: IDLE, RUN, DONE. The 2-bit encoding is free; any unused code returns to IDLE on the next edge.
- IDLE, start=1 on an edge:
  - load a_reg=a and b_reg = sub ? ~b : b;
  - carry=sub, count=0, result=0, cout=0, ovf=0;
  - go to RUN.
- IDLE, start=0: hold. Outputs keep their values; result holds the previous value or 0 after reset.
- RUN, each edge:
  - sum a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry, rippling within the digit;
  - shift result right by DIGIT and insert the DIGIT sum bits at result[WIDTH-1:WIDTH-DIGIT];
  - shift a_reg and b_reg right by DIGIT;
  - carry = carry-out of the digit; count = count+1.
- On the RUN edge where count == NDIG−1:
  - cout = carry out of the MSB;
  - ovf = (carry into MSB) XOR (carry out of MSB);
  - go to DONE.
- Latency: if start is sampled at edge 0, RUN covers edges 1..NDIG and done first reads 1 after edge NDIG. That is 8 cycles for the defaults. NDIG=1 gives a single RUN cycle.
- Counter width: max(1, clog2(NDIG)) bits. It never wraps inside one operation.
- DONE: result, cout and ovf are stable; done=1. On ack=1, go to IDLE (done drops after the edge) and keep result and flags.
- Ignored inputs:
  - start in RUN or DONE, including start and ack high together in DONE: go to IDLE only; start must be re-presented.
  - ack outside DONE.
  - sub, a and b outside the start-sampling edge. Operand changes during RUN do not affect the result.
- Arithmetic: unsigned modulo 2^WIDTH for result. ovf is meaningful for signed interpretation, cout for unsigned.

Test Plan:
- Add, defaults: a=0x3C, b=0x55, sub=0, start one cycle. Required: busy for 8 cycles, then done=1 with result=0x91, cout=0, ovf=1. ack drops done on the next edge; result stays 0x91.
- Subtract, defaults: a=0x10, b=0x20, sub=1. Required: result=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1: result=0x7F, cout=1, ovf=1.
- Wrap, defaults: a=0xFF, b=0x01 → result=0x00, cout=1, ovf=0. Changing a and b every cycle during RUN must not alter the result.
- WIDTH=16, DIGIT=4: a=0x7FFF, b=0x0001 → done after exactly 4 RUN cycles with result=0x8000, cout=0, ovf=1. Repeat with WIDTH=16, DIGIT=16 (1 RUN cycle).
- Reset mid-RUN: assert rst asynchronously after 3 RUN cycles. Required: immediately state=IDLE and all outputs 0. A following start with a=0x01, b=0x01 gives result=0x02.
- Handshake: start held high through RUN and DONE is ignored. ack and start together in DONE → IDLE for one cycle, then the still-high start launches a new operation. ack in IDLE has no effect.

Source files
------------

// File: rtl/add_sub_serial.sv
// rtl/add_sub_serial.sv - digit-serial adder/subtractor with done/ack handshake
//
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB first.
// Subtraction is a + ~b + 1, with the +1 supplied as the initial carry.
//
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-high reset
//   start   launch request, sampled only in IDLE
//   sub     0 = a+b, 1 = a-b, sampled with start
//   a, b    operands, sampled with start
//   ack     consumer has taken the result, sampled only in DONE
//   busy    high while the digits are being processed
//   done    high while result/cout/ovf are valid
//   result  sum or difference modulo 2^WIDTH
//   cout    carry out of the MSB (for subtract, 1 = no borrow)
//   ovf     two's-complement overflow
module add_sub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ack,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [CW-1:0]    count;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] s_dig;
   logic             c_out_dig;
   logic             c_into_msb;

   assign a_dig = a_reg[DIGIT-1:0];
   assign b_dig = b_reg[DIGIT-1:0];

   assign {c_out_dig, s_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};

   // The carry into the top bit of the digit is recovered from that bit's
   // sum: s = a ^ b ^ cin, so cin = s ^ a ^ b. Only used on the last digit,
   // where the top bit of the digit is the operand MSB.
   assign c_into_msb = s_dig[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         a_reg  <= '0;
         b_reg  <= '0;
         carry  <= 1'b0;
         count  <= '0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_reg  <= a;
                  b_reg  <= sub ? ~b : b;
                  carry  <= sub;
                  count  <= '0;
                  result <= '0;
                  cout   <= 1'b0;
                  ovf    <= 1'b0;
                  state  <= S_RUN;
               end
            end

            S_RUN: begin
               // New digit enters at the top; after NDIG shifts the first
               // digit has reached bit 0.
               result <= (WIDTH'(s_dig) << (WIDTH - DIGIT)) | (result >> DIGIT);
               a_reg  <= a_reg >> DIGIT;
               b_reg  <= b_reg >> DIGIT;
               carry  <= c_out_dig;
               count  <= count + CW'(1);
               if (count == LAST) begin
                  cout  <= c_out_dig;
                  ovf   <= c_into_msb ^ c_out_dig;
                  state <= S_DONE;
               end
            end

            S_DONE: begin
               // start alone is ignored here; with ack it still only
               // returns to IDLE and must be re-presented there.
               if (ack) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_sub_serial.sv
// tb/tb_add_sub_serial.sv - directed self-checking bench for add_sub_serial
module tb_add_sub_serial;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // default instance: WIDTH=8, DIGIT=1
   logic       start0 = 1'b0, sub0 = 1'b0, ack0 = 1'b0;
   logic [7:0] a0 = '0, b0 = '0;
   logic       busy0, done0, cout0, ovf0;
   logic [7:0] res0;

   // WIDTH=16, DIGIT=4
   logic        start1 = 1'b0, sub1 = 1'b0, ack1 = 1'b0;
   logic [15:0] a1 = '0, b1 = '0;
   logic        busy1, done1, cout1, ovf1;
   logic [15:0] res1;

   // WIDTH=16, DIGIT=16
   logic        start2 = 1'b0, sub2 = 1'b0, ack2 = 1'b0;
   logic [15:0] a2 = '0, b2 = '0;
   logic        busy2, done2, cout2, ovf2;
   logic [15:0] res2;

   add_sub_serial #(.WIDTH(8), .DIGIT(1)) u0 (
      .clk(clk), .rst(rst), .start(start0), .sub(sub0), .a(a0), .b(b0), .ack(ack0),
      .busy(busy0), .done(done0), .result(res0), .cout(cout0), .ovf(ovf0));

   add_sub_serial #(.WIDTH(16), .DIGIT(4)) u1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .ack(ack1),
      .busy(busy1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1));

   add_sub_serial #(.WIDTH(16), .DIGIT(16)) u2 (
      .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .ack(ack2),
      .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // present one start pulse to the 8-bit instance; returns just after edge 0
   task automatic launch0(input logic [7:0] a, input logic [7:0] b, input logic s);
      a0 = a; b0 = b; sub0 = s; start0 = 1'b1;
      step();
      start0 = 1'b0;
   endtask

   task automatic wait_done0(input string tag);
      int n = 0;
      while (!done0 && n < 50) begin
         step();
         n++;
      end
      chk(tag, {15'd0, done0}, 16'd1);
   endtask

   task automatic expect0(input string tag, input logic [7:0] r, input logic c, input logic v);
      chk({tag, "_result"}, {8'd0, res0}, {8'd0, r});
      chk({tag, "_cout"}, {15'd0, cout0}, {15'd0, c});
      chk({tag, "_ovf"}, {15'd0, ovf0}, {15'd0, v});
   endtask

   task automatic ack_0();
      ack0 = 1'b1;
      step();
      ack0 = 1'b0;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_busy", {15'd0, busy0}, 16'd0);
      chk("rst_done", {15'd0, done0}, 16'd0);
      chk("rst_result", {8'd0, res0}, 16'd0);
      chk("rst_flags", {14'd0, cout0, ovf0}, 16'd0);
      step();
      rst = 1'b0;
      step();

      // add 0x3C + 0x55: busy exactly 8 cycles
      launch0(8'h3C, 8'h55, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("add_busy_%0d", i), {14'd0, busy0, done0}, 16'b10);
         step();
      end
      chk("add_done_at_8", {14'd0, busy0, done0}, 16'b01);
      expect0("add", 8'h91, 1'b0, 1'b1);
      ack_0();
      chk("add_ack_done", {15'd0, done0}, 16'd0);
      expect0("add_hold", 8'h91, 1'b0, 1'b1);

      // ack in IDLE has no effect
      ack0 = 1'b1;
      step();
      step();
      ack0 = 1'b0;
      chk("idle_ack_state", {14'd0, busy0, done0}, 16'd0);
      chk("idle_ack_result", {8'd0, res0}, 16'h0091);

      // subtracts
      launch0(8'h10, 8'h20, 1'b1);
      wait_done0("sub1_timeout");
      expect0("sub1", 8'hF0, 1'b0, 1'b0);
      ack_0();
      launch0(8'h80, 8'h01, 1'b1);
      wait_done0("sub2_timeout");
      expect0("sub2", 8'h7F, 1'b1, 1'b1);
      ack_0();

      // wrap, with operands scrambled every RUN cycle
      launch0(8'hFF, 8'h01, 1'b0);
      for (int i = 0; i < 8; i++) begin
         a0 = 8'($urandom);
         b0 = 8'($urandom);
         sub0 = 1'($urandom);
         step();
      end
      chk("wrap_done", {15'd0, done0}, 16'd1);
      expect0("wrap", 8'h00, 1'b1, 1'b0);
      ack_0();

      // WIDTH=16 DIGIT=4: 4 RUN cycles
      a1 = 16'h7FFF; b1 = 16'h0001; sub1 = 1'b0; start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("w16d4_busy_%0d", i), {14'd0, busy1, done1}, 16'b10);
         step();
      end
      chk("w16d4_done", {14'd0, busy1, done1}, 16'b01);
      chk("w16d4_result", res1, 16'h8000);
      chk("w16d4_flags", {14'd0, cout1, ovf1}, 16'b01);

      // WIDTH=16 DIGIT=16: single RUN cycle
      a2 = 16'h7FFF; b2 = 16'h0001; sub2 = 1'b0; start2 = 1'b1;
      step();
      start2 = 1'b0;
      chk("w16d16_busy", {14'd0, busy2, done2}, 16'b10);
      step();
      chk("w16d16_done", {14'd0, busy2, done2}, 16'b01);
      chk("w16d16_result", res2, 16'h8000);
      chk("w16d16_flags", {14'd0, cout2, ovf2}, 16'b01);

      // asynchronous reset after 3 RUN cycles
      launch0(8'h3C, 8'h55, 1'b0);
      step();
      step();
      step();
      chk("pre_rst_busy", {15'd0, busy0}, 16'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_state", {14'd0, busy0, done0}, 16'd0);
      chk("mid_rst_result", {8'd0, res0}, 16'd0);
      chk("mid_rst_flags", {14'd0, cout0, ovf0}, 16'd0);
      step();
      rst = 1'b0;
      launch0(8'h01, 8'h01, 1'b0);
      wait_done0("post_rst_timeout");
      expect0("post_rst", 8'h02, 1'b0, 1'b0);
      ack_0();

      // start held through RUN and DONE; ack+start returns to IDLE only
      a0 = 8'h01; b0 = 8'h02; sub0 = 1'b0; start0 = 1'b1;
      step();
      for (int i = 0; i < 8; i++) step();
      chk("hs_done", {14'd0, busy0, done0}, 16'b01);
      a0 = 8'h05; b0 = 8'h06;
      step();
      step();
      chk("hs_hold_done", {14'd0, busy0, done0}, 16'b01);
      chk("hs_hold_result", {8'd0, res0}, 16'h0003);
      ack0 = 1'b1;
      step();
      ack0 = 1'b0;
      chk("hs_idle", {14'd0, busy0, done0}, 16'b00);
      chk("hs_idle_result", {8'd0, res0}, 16'h0003);
      step();
      chk("hs_relaunch", {14'd0, busy0, done0}, 16'b10);
      start0 = 1'b0;
      wait_done0("hs_timeout");
      expect0("hs2", 8'h0B, 1'b0, 1'b0);
      ack_0();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
